uart_rx_core: RTL and testbench

- Standalone UART receiver, 8N1 framing; parity is optional (see Optional Feature).
- Deserialises the serial line into bytes and presents each byte on a valid/ready output port.
- Serves as the receive-side counterpart to the wbuart32 transmit path in the 200 MHz verification environment.
- Used as a bench-side line monitor and as a reusable RTL receive core.

---
 rtl/uart_rx_core.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core
// -----------------------------------------------------------------------------
// UART receiver with 8N1 framing. It synchronises the asynchronous serial line,
// finds the falling edge of the start bit, and samples every bit at mid-bit. It
// presents each received byte on a valid/ready port that holds one byte.
//
// Optional build macro: UART_RX_PARITY_EN
//   When defined, a parity bit follows the data bits, and the ports
//   i_parity_odd and o_parity_err are added. When undefined, framing is pure 8N1.
//
// Parameters:
//   CLKS_PER_BAUD  clock cycles per bit period (>= 4)
//   SYNC_STAGES    depth of the input synchroniser (>= 2)
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   i_rx          serial line; idles high; asynchronous to clk
//   o_data        received byte; LSB is the first bit received
//   o_valid       o_data holds an unconsumed byte
//   i_ready       consumer accepts o_data when o_valid && i_ready
//   o_busy        a frame is in progress
//   o_frame_err   1-cycle pulse: the stop bit was sampled low
//   o_break       1-cycle pulse: all data bits and the stop bit were sampled low
//   o_overrun     1-cycle pulse: a byte was dropped because the output was full
//   i_parity_odd  (parity build) 0 = even parity, 1 = odd parity
//   o_parity_err  (parity build) 1-cycle pulse: the parity bit did not match
// -----------------------------------------------------------------------------
module uart_rx_core #(
  parameter int CLKS_PER_BAUD = 1736,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_frame_err,
  output logic       o_break,
  output logic       o_overrun
`ifdef UART_RX_PARITY_EN
  ,
  input  logic       i_parity_odd,
  output logic       o_parity_err
`endif
);

  localparam int CNT_W = $clog2(CLKS_PER_BAUD);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BAUD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BAUD / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_reg;
  logic [SYNC_STAGES-1:0] rx_sync;
  logic                   rx_s;
  logic                   rx_prev;
  logic                   start_edge;

  // ---- Stage: input synchroniser (flops reset to the line idle level)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync <= '1;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[SYNC_STAGES-2:0], i_rx};
      rx_prev <= rx_s;
    end
  end

  assign rx_s       = rx_sync[SYNC_STAGES-1];
  assign start_edge = rx_prev & ~rx_s;

  // The shift register holds data only. Every frame fully overwrites it
  // before it is used, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state == DATA && cnt == '0) begin
      shift_reg <= {rx_s, shift_reg[7:1]};
    end
  end

  // ---- Stage: frame FSM and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      o_data       <= 8'h00;
      o_valid      <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_edge) begin
            state  <= START;
            cnt    <= CNT_HALF;
            o_busy <= 1'b1;
          end
        end

        START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (!rx_s) begin
            state   <= DATA;
            cnt     <= CNT_FULL;
            bit_idx <= '0;
          end else begin
            // The line went high again before mid-bit, so this was a glitch.
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt     <= CNT_FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            cnt   <= CNT_FULL;
            state <= STOP;
            // XOR of the data bits and the parity bit equals i_parity_odd
            // when the parity is correct.
            if ((^shift_reg ^ rx_s) != i_parity_odd) begin
              o_parity_err <= 1'b1;
            end
          end
        end
`endif

        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            // A handshake in this cycle frees the slot, so the new byte can load.
            if (!o_valid || i_ready) begin
              o_data  <= shift_reg;
              o_valid <= 1'b1;
            end else begin
              o_overrun <= 1'b1;
            end
          end else begin
            o_frame_err <= 1'b1;
            o_break     <= (shift_reg == 8'h00);
            state       <= WAIT_HIGH;
          end
        end

        WAIT_HIGH: begin
          // A line held low must not start a new frame, so wait here for it to go high.
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core
// Directed and randomised bench for uart_rx_core with CLKS_PER_BAUD = 16.
// The reference model works at frame level. It keeps a queue of the bytes that
// should arrive and counters for the expected error pulses. A negedge monitor
// collects handshaked bytes and counts the pulses.
module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  // The start edge passes through the synchroniser and the edge detect. The
  // stop bit is then sampled at its middle, and the byte registers one edge later.
  localparam int LATENCY = CPB * (FRAME_BITS - 1) + CPB / 2 + SYNC + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic       i_ready = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_busy;
  logic       o_frame_err;
  logic       o_break;
  logic       o_overrun;
`ifdef UART_RX_PARITY_EN
  logic       i_parity_odd = 1'b0;
  logic       o_parity_err;
`endif

  uart_rx_core #(
    .CLKS_PER_BAUD(CPB),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_frame_err (o_frame_err),
    .o_break     (o_break),
    .o_overrun   (o_overrun)
`ifdef UART_RX_PARITY_EN
    ,
    .i_parity_odd(i_parity_odd),
    .o_parity_err(o_parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int fe_n = 0, brk_n = 0, ovr_n = 0, pe_n = 0, vld_n = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (o_valid) vld_n++;
      if (o_frame_err) fe_n++;
      if (o_break) brk_n++;
      if (o_overrun) ovr_n++;
`ifdef UART_RX_PARITY_EN
      if (o_parity_err) pe_n++;
`endif
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v);
    i_rx = v;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^b ^ i_parity_odd ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop_bit);
  endtask

  task automatic expect_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check(tag, got_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int lat;
    int fe0, brk0, ovr0;
    logic [7:0] b;

    // Reset state
    tick(3);
    check("rst_data", o_data, 8'h00);
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_flags", {o_frame_err, o_break, o_overrun}, 3'b000);
    rst_n = 1'b1;
    tick(5);
    check("idle_busy", o_busy, 1'b0);
    check("idle_valid", o_valid, 1'b0);

    // First byte: data value, latency and a one-cycle valid
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        while (!o_valid && lat < 400) begin
          tick(1);
          lat++;
        end
      end
    join
    tick(4);
    check("a5_latency", lat, LATENCY);
    check("a5_valid_cycles", vld_n, 1);
    exp_q.push_back(8'hA5);
    expect_bytes("a5_data");

    // Short low glitch
    fe0 = fe_n; brk0 = brk_n;
    i_rx = 1'b0;
    tick(5);
    check("glitch_busy_hi", o_busy, 1'b1);
    i_rx = 1'b1;
    tick(CPB);
    check("glitch_busy_lo", o_busy, 1'b0);
    check("glitch_flags", {fe_n - fe0, brk_n - brk0}, {32'd0, 32'd0});
    expect_bytes("glitch_data");

    // Frame error without break, then recovery
    fe0 = fe_n; brk0 = brk_n;
    send_frame(8'h3C, 1'b0, 1'b0);
    i_rx = 1'b1;
    tick(CPB);
    check("ferr_count", fe_n - fe0, 1);
    check("ferr_break", brk_n - brk0, 0);
    expect_bytes("ferr_data");
    send_frame(8'h81, 1'b1, 1'b0);
    tick(4);
    exp_q.push_back(8'h81);
    expect_bytes("after_ferr");

    // Break: line held low for 20 bit times
    fe0 = fe_n; brk0 = brk_n;
    i_rx = 1'b0;
    tick(20 * CPB);
    check("brk_ferr", fe_n - fe0, 1);
    check("brk_break", brk_n - brk0, 1);
    check("brk_busy_held", o_busy, 1'b1);
    i_rx = 1'b1;
    tick(CPB);
    check("brk_busy_release", o_busy, 1'b0);
    expect_bytes("brk_data");
    send_frame(8'h55, 1'b1, 1'b0);
    tick(4);
    exp_q.push_back(8'h55);
    expect_bytes("after_brk");

    // Overrun with the consumer stalled
    ovr0 = ovr_n;
    i_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(4);
    check("ovr_pulse", ovr_n - ovr0, 1);
    check("ovr_valid", o_valid, 1'b1);
    check("ovr_data_kept", o_data, 8'h11);
    i_ready = 1'b1;
    tick(2);
    check("ovr_drained", o_valid, 1'b0);
    exp_q.push_back(8'h11);
    expect_bytes("ovr_data");

    // Reset in the middle of the data bits
    fork
      send_frame(8'hF0, 1'b1, 1'b0);
      begin
        tick(CPB * 4);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_data", o_data, 8'h00);
      end
    join
    tick(2);
    rst_n = 1'b1;
    tick(CPB);
    send_frame(8'h0F, 1'b1, 1'b0);
    tick(4);
    exp_q.push_back(8'h0F);
    expect_bytes("after_rst");

    // Random bytes, including back-to-back frames
    fe0 = fe_n; ovr0 = ovr_n;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1, 1'b0);
      tick($urandom_range(0, 3));
    end
    tick(4);
    expect_bytes("rand");
    check("rand_no_flags", {fe_n - fe0, ovr_n - ovr0}, {32'd0, 32'd0});

`ifdef UART_RX_PARITY_EN
    // Odd parity: first a good parity bit, then a wrong one
    check("par_none_yet", pe_n, 0);
    i_parity_odd = 1'b1;
    send_frame(8'h6B, 1'b1, 1'b0);
    tick(4);
    check("par_good", pe_n, 0);
    send_frame(8'h6B, 1'b1, 1'b1);
    tick(4);
    check("par_bad", pe_n, 1);
    exp_q.push_back(8'h6B);
    exp_q.push_back(8'h6B);
    expect_bytes("par_data");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
